mem_data_responder: RTL and testbench

- Responder end of the memory-stage data-memory interface: accepts one load/store request at a time from the pipeline's memory stage and returns a completion response after a programmable access latency.
- Replaces the zero-latency combinational RAM with a valid/ready request channel and a valid/ready response channel, so the pipeline can be stalled on slow memory.
- Holds a word-addressed RAM internally and performs byte/half/word lane selection, plus sign or zero extension on loads.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_data_responder.sv | 149 ++++++++++++++
 tb/tb_mem_data_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access-size modes, FSM states
// and the misalignment rule used by the responder datapath.
package mem_pkg;

  localparam logic [1:0] MODE_WORD  = 2'b00;
  localparam logic [1:0] MODE_HALF  = 2'b01;
  localparam logic [1:0] MODE_BYTE  = 2'b10;
  localparam logic [1:0] MODE_UBYTE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] off);
    return ((mode == MODE_WORD) && (off != 2'b00)) ||
           ((mode == MODE_HALF) && off[0]);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the data-memory responder: byte enables and
// replicated store data on the write side, lane extraction plus extension on loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic signed [15:0] half_s;
  logic signed [7:0]  byte_s;

  always_comb begin
    byte_en   = 4'b0000;
    wdata_sh  = '0;
    rdata_ext = '0;
    half_s    = off[1] ? rword[31:16] : rword[15:0];
    byte_s    = rword[{off, 3'b000} +: 8];
    case (mode)
      MODE_WORD: begin
        byte_en   = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
      MODE_HALF: begin
        // Replicating the source lets the byte enables alone pick the destination.
        byte_en   = off[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = 32'(half_s);
      end
      default: begin
        byte_en   = 4'b0001 << off;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = (mode == MODE_BYTE) ? 32'(byte_s) : {24'h0, byte_s};
      end
    endcase
  end

endmodule

// File: rtl/mem_data_responder.sv
// Memory-stage data-memory responder: valid/ready request in, fixed-latency access to
// an internal word RAM, valid/ready response out. Define MEM_RESP_ERR_EN to flag
// misaligned accesses instead of aligning them down.
module mem_data_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   idx;
  logic [1:0]          off;
  logic                err_c;
  logic                commit;
  logic [3:0]          byte_en;
  logic [31:0]         wdata_sh;
  logic [31:0]         rdata_ext;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];
  assign idx    = addr_q[ADDR_W+1:2];
  assign commit = (state_q == ACCESS) && (cnt_q == 4'd0);

`ifdef MEM_RESP_ERR_EN
  assign off   = addr_q[1:0];
  assign err_c = is_misaligned(mode_q, addr_q[1:0]);
`else
  // Without error reporting, the offending low address bits are simply dropped.
  always_comb begin
    case (mode_q)
      MODE_WORD: off = 2'b00;
      MODE_HALF: off = {addr_q[1], 1'b0};
      default:   off = addr_q[1:0];
    endcase
  end
  assign err_c = 1'b0;
`endif

  mem_lane_align u_lane_align (
    .mode      (mode_q),
    .off       (off),
    .wdata     (wdata_q),
    .rword     (mem[idx]),
    .byte_en   (byte_en),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)  state_d = ACCESS;
      ACCESS:  if (commit)     state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = rst_n && (state_q == IDLE);
    resp_valid = (state_q == RESP);
  end

  always_comb begin
    wr_d    = wr_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if ((state_q == IDLE) && req_valid) begin
      wr_d    = req_write;
      mode_d  = req_mode;
      addr_d  = req_addr[ADDR_W+1:0];
      wdata_d = req_wdata;
      cnt_d   = 4'(LATENCY - 1);
    end else if (state_q == ACCESS) begin
      if (commit) begin
        rdata_d = (wr_q || err_c) ? 32'h0 : rdata_ext;
        err_d   = err_c;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Captured request fields are only consumed while in ACCESS, so they need no reset.
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    mode_q  <= mode_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk) begin
    if (commit && wr_q && !err_c) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[idx][8*k +: 8] <= wdata_sh[8*k +: 8];
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_data_responder.sv
// Randomized scoreboard bench for mem_data_responder; expectations come from a
// byte-level memory model that follows the access rules directly.
module tb_mem_data_responder;
  import mem_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 2 ** ADDR_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    bit [31:0] rd;
    bit        err;
  } exp_t;

  exp_t      sbq[$];
  bit [31:0] mdl [DEPTH];
  int        checks = 0;
  int        errors = 0;

  mem_data_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_mode   (req_mode),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference model: memory as bytes, access size in bytes, little-endian.
  function automatic void model(input bit wr, input bit [1:0] mode, input bit [31:0] addr,
                                input bit [31:0] wd, output bit [31:0] rd, output bit err);
    int idx  = int'((addr >> 2) % DEPTH);
    int off  = int'(addr % 4);
    int size = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 2 : 1;
    bit [31:0] v = 32'h0;
    rd  = 32'h0;
    err = 1'b0;
`ifdef MEM_RESP_ERR_EN
    if ((off % size) != 0) begin
      err = 1'b1;
      return;
    end
`else
    off = off - (off % size);
`endif
    if (wr) begin
      for (int b = 0; b < size; b++) mdl[idx][8*(off+b) +: 8] = wd[8*b +: 8];
    end else begin
      for (int b = 0; b < size; b++) v[8*b +: 8] = mdl[idx][8*(off+b) +: 8];
      if (mode == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      if (mode == 2'd2 && v[7])  v = v | 32'hFFFF_FF00;
      rd = v;
    end
  endfunction

  // Monitor: a response is consumed at the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (sbq.size() == 0) begin
        chk1("unexpected_response", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk32("resp_rdata", resp_rdata, e.rd);
        chk1("resp_err", resp_err, e.err);
      end
    end
  end

  task automatic do_txn(input bit wr, input bit [1:0] mode, input bit [31:0] addr,
                        input bit [31:0] wd, input bit bp);
    exp_t e;
    bit   hs;
    model(wr, mode, addr, wd, e.rd, e.err);
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_mode  = mode;
    req_addr  = addr;
    req_wdata = wd;
    chk1("req_ready_idle", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_mode  = 2'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    resp_ready = bp ? 1'($urandom) : 1'b1;
    chk1("resp_valid_early", resp_valid, 1'b0);
    for (int i = 1; i < LATENCY; i++) begin
      @(posedge clk); #1;
      chk1("resp_valid_early", resp_valid, 1'b0);
    end
    @(posedge clk); #1;
    chk1("resp_valid_latency", resp_valid, 1'b1);
    hs = 1'b0;
    for (int n = 0; n < 40 && !hs; n++) begin
      resp_ready = bp ? 1'($urandom) : 1'b1;
      @(negedge clk);
      hs = resp_valid && resp_ready;
      @(posedge clk); #1;
    end
    chk1("resp_handshake", hs, 1'b1);
    chk1("resp_valid_after", resp_valid, 1'b0);
    chk1("req_ready_after", req_ready, 1'b1);
    resp_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_mode   = 2'b00;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk32("rst_resp_rdata", resp_rdata, 32'h0);
    chk1("rst_resp_err", resp_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("idle_req_ready", req_ready, 1'b1);

    do_txn(1'b1, MODE_WORD,  32'h10, 32'hDEADBEEF, 1'b0);
    do_txn(1'b0, MODE_WORD,  32'h10, 32'h0, 1'b0);
    do_txn(1'b0, MODE_BYTE,  32'h13, 32'h0, 1'b0);
    do_txn(1'b0, MODE_UBYTE, 32'h13, 32'h0, 1'b0);
    do_txn(1'b0, MODE_HALF,  32'h12, 32'h0, 1'b0);
    do_txn(1'b1, MODE_BYTE,  32'h11, 32'h00000055, 1'b0);
    do_txn(1'b0, MODE_WORD,  32'h10, 32'h0, 1'b0);
    do_txn(1'b1, MODE_WORD,  32'h20, 32'hCAFEF00D, 1'b0);
    do_txn(1'b0, MODE_WORD,  32'h10, 32'h0, 1'b0);

    // Abort: reset lands between acceptance and the commit edge of a store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_mode  = MODE_WORD;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk1("abort_req_ready", req_ready, 1'b0);
    chk1("abort_resp_valid", resp_valid, 1'b0);
    chk32("abort_resp_rdata", resp_rdata, 32'h0);
    chk1("abort_resp_err", resp_err, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("abort_idle", req_ready, 1'b1);
    do_txn(1'b0, MODE_WORD,  32'h20, 32'h0, 1'b0);
    do_txn(1'b0, MODE_WORD,  32'h410, 32'h0, 1'b0);
    do_txn(1'b0, MODE_UBYTE, 32'hABCD_0411, 32'h0, 1'b0);

    // Backpressure: response held for 5 cycles while a competing store is offered.
    model(1'b0, MODE_WORD, 32'h10, 32'h0, e.rd, e.err);
    sbq.push_back(e);
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_mode  = MODE_WORD;
    req_addr  = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("bp_valid", resp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_mode  = MODE_WORD;
      req_addr  = 32'h10;
      req_wdata = 32'h0;
      @(posedge clk); #1;
      chk1("bp_hold_valid", resp_valid, 1'b1);
      chk32("bp_hold_rdata", resp_rdata, e.rd);
      chk1("bp_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk1("bp_release_valid", resp_valid, 1'b0);
    chk1("bp_release_idle", req_ready, 1'b1);
    req_valid = 1'b0;
    do_txn(1'b0, MODE_WORD, 32'h10, 32'h0, 1'b0);

    do_txn(1'b0, MODE_WORD, 32'h11, 32'h0, 1'b0);
    do_txn(1'b1, MODE_HALF, 32'h13, 32'h0000BEEF, 1'b0);
    do_txn(1'b0, MODE_WORD, 32'h10, 32'h0, 1'b0);

    for (int i = 0; i < 16; i++) do_txn(1'b1, MODE_WORD, 32'(i * 4), $urandom, 1'b0);
    for (int i = 0; i < 300; i++) begin
      bit [31:0] a;
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      do_txn(1'($urandom), 2'($urandom), a, $urandom, 1'b1);
    end

    chk32("scoreboard_drain", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
